// File: rtl/divmmc_spi_if.sv
// CPU-side bus strobes and SD-card SPI pins of the DivMMC SPI master.
// slave = the SPI block, master = the CPU bus / card side driving it.
interface divmmc_spi_if;
  logic       iorq;
  logic       rd;
  logic       wr;
  logic [7:0] a;
  logic [7:0] d;
  logic [7:0] q;
  logic [1:0] cs;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       busy;

  modport master (
    output iorq, rd, wr, a, d, miso,
    input  q, cs, sck, mosi, busy
  );

  modport slave (
    input  iorq, rd, wr, a, d, miso,
    output q, cs, sck, mosi, busy
  );
endinterface

// File: rtl/divmmc_spi.sv
// DivMMC SPI master: port 0xE7 sets card selects, each 0xEB access runs one mode-0 byte transfer.
// A bus trigger is registered, then acted on one cycle later; 0xEB triggers while busy are dropped.
module divmmc_spi #(
  parameter int unsigned DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  divmmc_spi_if.slave bus
);

  localparam logic [7:0] PORT_CS   = 8'hE7;
  localparam logic [7:0] PORT_DATA = 8'hEB;
  localparam logic [7:0] PH_LAST   = 8'(DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic        acc_q, acc_d;
  logic        start_q, start_d;
  logic [7:0]  txv_q, txv_d;
  logic        cs_wr_q, cs_wr_d;
  logic [1:0]  csv_q, csv_d;
  logic [7:0]  phase_q, phase_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  q_q, q_d;
  logic        busy_q, busy_d;
  logic [1:0]  cs_q, cs_d;

  logic acc_now;
  logic trig;

  assign acc_now = !bus.iorq && (!bus.rd || !bus.wr) &&
                   ((bus.a == PORT_CS) || (bus.a == PORT_DATA));
  assign trig    = acc_now && !acc_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    q_d      = q_q;
    busy_d   = busy_q;
    cs_d     = cs_q;

    acc_d    = acc_now;
    cs_wr_d  = trig && (bus.a == PORT_CS) && !bus.wr;
    csv_d    = bus.d[1:0];
    // Busy is judged at the sampling edge, so a trigger landing on the completion edge is dropped.
    start_d  = trig && (bus.a == PORT_DATA) && (state_q == IDLE);
    txv_d    = !bus.wr ? bus.d : 8'hFF;

    if (cs_wr_q) cs_d = csv_q;

    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d  = SHIFT;
          tx_d     = txv_q;
          mosi_d   = txv_q[7];
          busy_d   = 1'b1;
          phase_d  = '0;
          bitcnt_d = '0;
          sck_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          sck_d   = !sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], bus.miso};
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_d = IDLE;
              q_d     = rx_q;
              busy_d  = 1'b0;
              mosi_d  = 1'b1;
              sck_d   = 1'b0;
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              mosi_d = tx_q[6];
            end
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= 1'b0;
      start_q  <= 1'b0;
      txv_q    <= 8'hFF;
      cs_wr_q  <= 1'b0;
      csv_q    <= 2'b11;
      phase_q  <= '0;
      bitcnt_q <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b1;
      tx_q     <= 8'hFF;
      rx_q     <= 8'hFF;
      q_q      <= 8'hFF;
      busy_q   <= 1'b0;
      cs_q     <= 2'b11;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      start_q  <= start_d;
      txv_q    <= txv_d;
      cs_wr_q  <= cs_wr_d;
      csv_q    <= csv_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      q_q      <= q_d;
      busy_q   <= busy_d;
      cs_q     <= cs_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.cs   = cs_q;
  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_divmmc_spi.sv
// Bench for divmmc_spi: random Z80 port accesses, transfer-level reference model, queue scoreboard.
module tb_divmmc_spi;
  localparam int DIV  = 2;
  localparam int XFER = 16 * DIV;

  logic clock = 1'b0;
  logic reset = 1'b1;

  divmmc_spi_if bus ();

  divmmc_spi #(.DIV(DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // SD card model: shifts out miso_byte MSB first, one bit per SCK rise.
  logic [7:0] miso_byte = 8'hFF;
  logic [2:0] miso_idx  = 3'd0;
  assign bus.miso = miso_byte[3'd7 - miso_idx];

  // Expected transfers: byte on MOSI, byte that lands in q, completion cycle.
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int         exp_done[$];

  // Reference model state.
  int         free_t0    = 0;
  logic [7:0] model_q    = 8'hFF;
  bit         pend_valid = 1'b0;
  logic [7:0] pend_rx    = 8'hFF;
  int         pend_done  = 0;
  logic [1:0] model_cs   = 2'b11;

  logic       busy_p = 1'b0;
  logic       sck_p  = 1'b0;
  int         blen   = 0;
  logic [7:0] txb    = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_t0    = 0;
    model_q    = 8'hFF;
    pend_valid = 1'b0;
    model_cs   = 2'b11;
  endtask

  task automatic bus_op(input bit is_wr, input logic [7:0] addr, input logic [7:0] dat,
                        input int len, input logic [7:0] mb, output int t0);
    logic [1:0] cs_old;
    logic [7:0] q_exp;
    @(posedge clock);
    #1;
    bus.iorq = 1'b0;
    bus.a    = addr;
    bus.d    = dat;
    if (is_wr) bus.wr = 1'b0;
    else       bus.rd = 1'b0;
    t0 = cyc + 1;

    q_exp  = (pend_valid && (t0 - 1) >= pend_done) ? pend_rx : model_q;
    cs_old = model_cs;
    if (is_wr && addr == 8'hE7) model_cs = dat[1:0];
    if (addr == 8'hEB && t0 >= free_t0) begin
      if (pend_valid) model_q = pend_rx;
      pend_valid = 1'b1;
      pend_rx    = mb;
      pend_done  = t0 + XFER + 1;
      free_t0    = t0 + XFER + 2;
      miso_byte  = mb;
      exp_tx.push_back(is_wr ? dat : 8'hFF);
      exp_rx.push_back(mb);
      exp_done.push_back(pend_done);
    end

    @(negedge clock);
    if (!is_wr && addr == 8'hEB) chk("read_q", 32'(bus.q), 32'(q_exp));
    @(posedge clock);
    @(negedge clock);
    chk("cs_before", 32'(bus.cs), 32'(cs_old));
    @(posedge clock);
    @(negedge clock);
    chk("cs_after", 32'(bus.cs), 32'(model_cs));
    repeat (len) @(posedge clock);
    #1;
    bus.iorq = 1'b1;
    bus.rd   = 1'b1;
    bus.wr   = 1'b1;
  endtask

  task automatic wait_idle();
    while (cyc < free_t0 + 2) @(posedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"},   32'(bus.cs),   'h3);
    chk({tag, "_sck"},  32'(bus.sck),  'h0);
    chk({tag, "_mosi"}, 32'(bus.mosi), 'h1);
    chk({tag, "_q"},    32'(bus.q),    'hFF);
    chk({tag, "_busy"}, 32'(bus.busy), 'h0);
  endtask

  // Monitor: checks each finished transfer against the scoreboard, and idle pins otherwise.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_tx.delete();
        exp_rx.delete();
        exp_done.delete();
        busy_p   = 1'b0;
        sck_p    = 1'b0;
        blen     = 0;
        miso_idx = 3'd0;
      end else begin
        if (bus.busy) begin
          if (!busy_p) begin
            blen     = 0;
            miso_idx = 3'd0;
          end
          blen++;
          if (bus.sck && !sck_p) begin
            txb      = {txb[6:0], bus.mosi};
            miso_idx = miso_idx + 3'd1;
          end
        end else begin
          chk("idle_sck", 32'(bus.sck), 'h0);
          chk("idle_mosi", 32'(bus.mosi), 'h1);
          if (busy_p) begin
            chk("xfer_expected", 32'(exp_rx.size() != 0), 'h1);
            if (exp_rx.size() != 0) begin
              chk("rx_q",      32'(bus.q), 32'(exp_rx.pop_front()));
              chk("tx_byte",   32'(txb),   32'(exp_tx.pop_front()));
              chk("done_cyc",  cyc,        exp_done.pop_front());
              chk("busy_len",  blen,       XFER);
            end
          end
        end
        busy_p = bus.busy;
        sck_p  = bus.sck;
      end
    end
  end

  initial begin
    int t0;
    int tb;
    logic [7:0] addrs [4];
    addrs[0] = 8'hE7;
    addrs[1] = 8'hEB;
    addrs[2] = 8'hEB;
    addrs[3] = 8'h1F;

    bus.iorq = 1'b1;
    bus.rd   = 1'b1;
    bus.wr   = 1'b1;
    bus.a    = 8'h00;
    bus.d    = 8'h00;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_vals("in_reset");
    #1 reset = 1'b0;
    repeat (4) @(negedge clock);
    chk_reset_vals("after_reset");

    bus_op(1'b1, 8'hE7, 8'h02, 0, 8'h00, t0);
    bus_op(1'b1, 8'hEB, 8'hA5, 1, 8'h3C, t0);
    wait_idle();
    bus_op(1'b0, 8'hEB, 8'h00, 0, 8'h81, t0);
    wait_idle();

    bus_op(1'b1, 8'hEB, 8'hC3, 0, 8'($urandom), t0);
    while (cyc < t0 + 8) @(posedge clock);
    bus_op(1'b1, 8'hEB, 8'h55, 0, 8'hEE, tb);
    bus_op(1'b1, 8'hE7, 8'h03, 0, 8'h00, tb);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      bus_op(1'($urandom), addrs[$urandom_range(0, 3)], 8'($urandom),
             int'($urandom_range(0, 3)), 8'($urandom), t0);
      repeat ($urandom_range(0, 40)) @(posedge clock);
    end
    wait_idle();

    bus_op(1'b1, 8'hEB, 8'h5A, 0, 8'h96, t0);
    while (cyc < t0 + 1 + 7 * DIV) @(posedge clock);
    @(negedge clock);
    chk("pulse4_sck", 32'(bus.sck), 'h1);
    #1 reset = 1'b1;
    #1 chk_reset_vals("mid_xfer_reset");
    model_reset();
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_vals("after_abort");
    bus_op(1'b1, 8'hEB, 8'h3D, 0, 8'hC7, t0);
    wait_idle();
    repeat (4) @(posedge clock);

    chk("queue_drained", exp_rx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
